// File: rtl/morse_encoder_pkg.sv
// Shared definitions for the Morse encoder slice.
// Holds the FSM state type, unit-length constants, ASCII constants, the
// packed pattern record returned by the lookup table, and a case-fold helper.
package morse_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_MARK,
        ST_SPACE,
        ST_GAP
    } state_t;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

    localparam logic [7:0] ASCII_SPACE       = 8'h20;
    localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

    // Symbol i of a character is bits[i] (LSB first), 1 = dash.
    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] len;
        logic [4:0] bits;
    } pattern_t;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_Z) begin
            return c - ASCII_CASE_OFFSET;
        end
        return c;
    endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// FIFO read-side handshake between the character FIFO and the encoder.
//   empty_i : FIFO empty flag
//   rdata_i : FIFO read data, valid the cycle after read_o is sampled high
//   read_o  : one-cycle read strobe issued by the encoder
// master = FIFO side, slave = encoder side.
interface morse_encoder_if #(
    parameter int WORD_BITS = 8
);
    logic                 empty_i;
    logic [WORD_BITS-1:0] rdata_i;
    logic                 read_o;

    modport master (output empty_i, output rdata_i, input read_o);
    modport slave  (input empty_i, input rdata_i, output read_o);
endinterface

// File: rtl/morse_encoder_lut.sv
// Combinational Morse lookup for uppercase A-Z and 0-9.
//   char_i     : uppercase ASCII character
//   valid_o    : character has a Morse pattern
//   is_space_o : character is ASCII space
//   len_o      : number of symbols (1-5)
//   bits_o     : symbol i = bits_o[i], 1 = dash
module morse_encoder_lut
    import morse_encoder_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       valid_o,
    output logic       is_space_o,
    output logic [2:0] len_o,
    output logic [4:0] bits_o
);

    pattern_t pat;

    function automatic pattern_t code(input logic [2:0] l, input logic [4:0] b);
        return '{valid: 1'b1, is_space: 1'b0, len: l, bits: b};
    endfunction

    always_comb begin
        pat = '0;
        case (char_i)
            8'h41: pat = code(3'd2, 5'b00010); // A .-
            8'h42: pat = code(3'd4, 5'b00001); // B -...
            8'h43: pat = code(3'd4, 5'b00101); // C -.-.
            8'h44: pat = code(3'd3, 5'b00001); // D -..
            8'h45: pat = code(3'd1, 5'b00000); // E .
            8'h46: pat = code(3'd4, 5'b00100); // F ..-.
            8'h47: pat = code(3'd3, 5'b00011); // G --.
            8'h48: pat = code(3'd4, 5'b00000); // H ....
            8'h49: pat = code(3'd2, 5'b00000); // I ..
            8'h4A: pat = code(3'd4, 5'b01110); // J .---
            8'h4B: pat = code(3'd3, 5'b00101); // K -.-
            8'h4C: pat = code(3'd4, 5'b00010); // L .-..
            8'h4D: pat = code(3'd2, 5'b00011); // M --
            8'h4E: pat = code(3'd2, 5'b00001); // N -.
            8'h4F: pat = code(3'd3, 5'b00111); // O ---
            8'h50: pat = code(3'd4, 5'b00110); // P .--.
            8'h51: pat = code(3'd4, 5'b01011); // Q --.-
            8'h52: pat = code(3'd3, 5'b00010); // R .-.
            8'h53: pat = code(3'd3, 5'b00000); // S ...
            8'h54: pat = code(3'd1, 5'b00001); // T -
            8'h55: pat = code(3'd3, 5'b00100); // U ..-
            8'h56: pat = code(3'd4, 5'b01000); // V ...-
            8'h57: pat = code(3'd3, 5'b00110); // W .--
            8'h58: pat = code(3'd4, 5'b01001); // X -..-
            8'h59: pat = code(3'd4, 5'b01101); // Y -.--
            8'h5A: pat = code(3'd4, 5'b00011); // Z --..
            8'h30: pat = code(3'd5, 5'b11111); // 0 -----
            8'h31: pat = code(3'd5, 5'b11110); // 1 .----
            8'h32: pat = code(3'd5, 5'b11100); // 2 ..---
            8'h33: pat = code(3'd5, 5'b11000); // 3 ...--
            8'h34: pat = code(3'd5, 5'b10000); // 4 ....-
            8'h35: pat = code(3'd5, 5'b00000); // 5 .....
            8'h36: pat = code(3'd5, 5'b00001); // 6 -....
            8'h37: pat = code(3'd5, 5'b00011); // 7 --...
            8'h38: pat = code(3'd5, 5'b00111); // 8 ---..
            8'h39: pat = code(3'd5, 5'b01111); // 9 ----.
            ASCII_SPACE: pat.is_space = 1'b1;
            default: pat = '0;
        endcase
    end

    assign valid_o    = pat.valid;
    assign is_space_o = pat.is_space;
    assign len_o      = pat.len;
    assign bits_o     = pat.bits;

endmodule

// File: rtl/morse_encoder.sv
// Morse encoder: pops ASCII characters from the FIFO and keys signal_o with
// standard unit timing (dot 1, dash 3, symbol gap 1, letter gap 3, word gap 7).
//   clk_i    : system clock
//   reset_i  : synchronous active-high reset
//   fifo     : FIFO read handshake (empty_i, rdata_i, read_o)
//   signal_o : key output, 1 = tone/LED on
//   busy_o   : high whenever the FSM is not idle
//   skip_o   : one-cycle pulse for a character with no Morse code
module morse_encoder
    import morse_encoder_pkg::*;
#(
    parameter int WORD_BITS     = 8,
    parameter int CLKS_PER_UNIT = 12_000_000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    morse_encoder_if.slave    fifo,
    output logic              signal_o,
    output logic              busy_o,
    output logic              skip_o
);

    localparam int              TICK_W    = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_UNIT - 1);

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [2:0]           unit_q, unit_d;
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           gap_q, gap_d;
    logic [7:0]           char_q, char_d;
    logic                 skip_q, skip_d;

    logic [WORD_BITS-1:0] rdata_w;
    logic [7:0]           rx_char, lut_char;
    logic                 lut_valid, lut_is_space;
    logic [2:0]           lut_len, lut_bits_len_unused_guard;
    logic [4:0]           lut_bits;
    logic [2:0]           need;
    logic                 tick_last, unit_done;

    assign rdata_w  = fifo.rdata_i;
    assign rx_char  = to_upper(rdata_w[7:0]);
    // The LUT looks at the incoming byte while loading, then at the held char.
    assign lut_char = (state_q == ST_LOAD) ? rx_char : char_q;
    assign lut_bits_len_unused_guard = lut_len;

    morse_encoder_lut u_lut (
        .char_i     (lut_char),
        .valid_o    (lut_valid),
        .is_space_o (lut_is_space),
        .len_o      (lut_len),
        .bits_o     (lut_bits)
    );

    always_comb begin
        need = gap_q;
        case (state_q)
            ST_MARK:  need = lut_bits[idx_q] ? DASH_UNITS : DOT_UNITS;
            ST_SPACE: need = SYM_GAP_UNITS;
            default:  need = gap_q;
        endcase
    end

    assign tick_last = (tick_q == TICK_LAST);
    assign unit_done = tick_last && (unit_q == need - 3'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        char_d  = char_q;
        skip_d  = 1'b0;
        case (state_q)
            ST_IDLE:  if (!fifo.empty_i) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                char_d = rx_char;
                if (lut_valid) begin
                    state_d = ST_MARK;
                    idx_d   = '0;
                end else if (lut_is_space) begin
                    state_d = ST_GAP;
                    gap_d   = WORD_EXTRA_UNITS;
                end else begin
                    // Unknown char: skip_o is registered, so it is shown during
                    // a zero-length GAP cycle before returning to IDLE.
                    state_d = ST_GAP;
                    gap_d   = '0;
                    skip_d  = 1'b1;
                end
            end
            ST_MARK: begin
                if (unit_done) begin
                    if (idx_q == lut_bits_len_unused_guard - 3'd1) begin
                        state_d = ST_GAP;
                        gap_d   = LETTER_GAP_UNITS;
                    end else begin
                        state_d = ST_SPACE;
                    end
                end
            end
            ST_SPACE: begin
                if (unit_done) begin
                    state_d = ST_MARK;
                    idx_d   = idx_q + 3'd1;
                end
            end
            ST_GAP:   if (gap_q == '0 || unit_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            tick_d = '0;
            unit_d = '0;
        end else if (tick_last) begin
            tick_d = '0;
            unit_d = unit_q + 3'd1;
        end else begin
            tick_d = tick_q + TICK_W'(1);
            unit_d = unit_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            unit_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            char_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            unit_q  <= unit_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            char_q  <= char_d;
            skip_q  <= skip_d;
        end
    end

    assign fifo.read_o = (state_q == ST_FETCH);
    assign signal_o    = (state_q == ST_MARK);
    assign busy_o      = (state_q != ST_IDLE);
    assign skip_o      = skip_q;

endmodule
